// File: rtl/fifo_access_arbiter.sv
// Round-robin write arbiter for two producers plus a single-consumer read
// sequencer, placed directly in front of a DEPTH x WIDTH fifo.
module fifo_access_arbiter #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int CW    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             p0_valid,
  input  logic [WIDTH-1:0] p0_data,
  output logic             p0_ready,
  input  logic             p1_valid,
  input  logic [WIDTH-1:0] p1_data,
  output logic             p1_ready,
  input  logic             c_rd_req,
  output logic             c_valid,
  output logic [WIDTH-1:0] c_data,
  output logic             fifo_wr_n,
  output logic             fifo_rd_n,
  output logic [WIDTH-1:0] fifo_data_in,
  input  logic [WIDTH-1:0] fifo_data_out,
  input  logic             fifo_over_flow,
  input  logic             fifo_under_flow,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             err
);

  logic [CW-1:0] count_q, count_d;
  logic          last_q, last_d;
  logic          c_valid_q, c_valid_d;
  logic          err_q, err_d;
  logic          space, grant0, grant1, wr_go, rd_go;

  // Strobes are gated by rst_n so the fifo sees no access while reset is held.
  always_comb begin
    space  = (count_q < CW'(DEPTH));
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n && space) begin
      if (p0_valid && p1_valid) begin
        grant0 = last_q;
        grant1 = ~last_q;
      end else begin
        grant0 = p0_valid;
        grant1 = p1_valid;
      end
    end
    wr_go = grant0 | grant1;
    rd_go = rst_n & c_rd_req & (count_q != '0);
  end

  always_comb begin
    count_d = count_q;
    case ({wr_go, rd_go})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    last_d = last_q;
    if (grant1) begin
      last_d = 1'b1;
    end else if (grant0) begin
      last_d = 1'b0;
    end
    c_valid_d = rd_go;
    err_d     = err_q | fifo_over_flow | fifo_under_flow;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      last_q    <= 1'b1;
      c_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      last_q    <= last_d;
      c_valid_q <= c_valid_d;
      err_q     <= err_d;
    end
  end

  assign p0_ready     = grant0;
  assign p1_ready     = grant1;
  assign fifo_wr_n    = ~wr_go;
  assign fifo_rd_n    = ~rd_go;
  assign fifo_data_in = grant1 ? p1_data : p0_data;
  assign c_valid      = c_valid_q;
  assign c_data       = c_valid_q ? fifo_data_out : '0;
  assign count        = count_q;
  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign err          = err_q;

endmodule

// File: tb/tb_fifo_access_arbiter.sv
// Bench for fifo_access_arbiter: directed scenarios plus random traffic,
// checked against a queue-based model of the arbiter and an attached fifo stand-in.
module tb_fifo_access_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       p0_valid = 1'b0, p1_valid = 1'b0, c_rd_req = 1'b0;
  logic [7:0] p0_data = '0, p1_data = '0;
  logic       p0_ready, p1_ready, c_valid, fifo_wr_n, fifo_rd_n;
  logic [7:0] c_data, fifo_data_in;
  logic [7:0] fifoDout;
  logic       ovf = 1'b0, unf = 1'b0;
  logic [4:0] count;
  logic       full, empty, err;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;
  int cycleNo    = 0;

  int         mCount;
  bit         mLast;
  logic [7:0] mQ[$];
  bit         mCvalid;
  logic [7:0] mCdata;
  bit         mErr;
  int         n0, n1;

  logic [7:0] fq[$];

  fifo_access_arbiter #(.DEPTH(16), .WIDTH(8), .CW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_valid(p0_valid), .p0_data(p0_data), .p0_ready(p0_ready),
    .p1_valid(p1_valid), .p1_data(p1_data), .p1_ready(p1_ready),
    .c_rd_req(c_rd_req), .c_valid(c_valid), .c_data(c_data),
    .fifo_wr_n(fifo_wr_n), .fifo_rd_n(fifo_rd_n), .fifo_data_in(fifo_data_in),
    .fifo_data_out(fifoDout), .fifo_over_flow(ovf), .fifo_under_flow(unf),
    .count(count), .full(full), .empty(empty), .err(err)
  );

  always #5 clk = ~clk;

  // Stand-in for the attached 16-deep fifo with registered read data.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
      fifoDout <= '0;
    end else begin
      if (!fifo_rd_n) begin
        if (fq.size() > 0) fifoDout <= fq.pop_front();
        else fifoDout <= '0;
      end
      if (!fifo_wr_n) fq.push_back(fifo_data_in);
    end
  end

  task automatic modelReset();
    mCount  = 0;
    mLast   = 1'b1;
    mQ.delete();
    mCvalid = 1'b0;
    mCdata  = '0;
    mErr    = 1'b0;
    n0      = 0;
    n1      = 0;
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) begin
      passCount++;
    end else begin
      failCount++;
      $error("[TB] FAIL %s cycle %0d: observed %0h expected %0h", tag, cycleNo, obs, exp);
    end
  endtask

  task automatic checkOutput(input int g, input bit rdGo, input logic [7:0] wdata);
    checkVal("p0_ready", p0_ready, (g == 0));
    checkVal("p1_ready", p1_ready, (g == 1));
    checkVal("fifo_wr_n", fifo_wr_n, !(g >= 0));
    checkVal("fifo_rd_n", fifo_rd_n, !rdGo);
    if (g >= 0) checkVal("fifo_data_in", fifo_data_in, wdata);
    checkVal("count", count, mCount);
    checkVal("full", full, (mCount == 16));
    checkVal("empty", empty, (mCount == 0));
    checkVal("c_valid", c_valid, mCvalid);
    checkVal("c_data", c_data, mCvalid ? mCdata : 8'h00);
    checkVal("err", err, mErr);
  endtask

  task automatic applyStimulus(input logic v0, input logic [7:0] d0,
                               input logic v1, input logic [7:0] d1, input logic rd);
    int         g;
    bit         rdGo;
    logic [7:0] wdata;
    p0_valid = v0;
    p0_data  = d0;
    p1_valid = v1;
    p1_data  = d1;
    c_rd_req = rd;
    #2;
    g = -1;
    if (rst_n && mCount < 16) begin
      if (v0 && v1) g = mLast ? 0 : 1;
      else if (v0) g = 0;
      else if (v1) g = 1;
    end
    rdGo  = rst_n && rd && (mCount > 0);
    wdata = (g == 1) ? d1 : d0;
    checkOutput(g, rdGo, wdata);
    @(posedge clk);
    if (rst_n) begin
      mCvalid = rdGo;
      if (rdGo) mCdata = mQ.pop_front();
      if (g >= 0) begin
        mQ.push_back(wdata);
        mLast = (g == 1);
        if (g == 0) n0++;
        else n1++;
      end
      mCount = mCount + int'(g >= 0) - int'(rdGo);
      mErr   = mErr | ovf | unf;
    end
    cycleNo++;
    #1;
  endtask

  // Reset held for a few cycles with every input active.
  task automatic doReset(input int cycles);
    rst_n = 1'b0;
    modelReset();
    for (int i = 0; i < cycles; i++)
      applyStimulus(1'b1, 8'($urandom), 1'b1, 8'($urandom), 1'b1);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] expWord;
    modelReset();

    doReset(3);
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h5A, 1'b0);

    doReset(3);
    for (int k = 0; k < 18; k++)
      applyStimulus(1'b1, 8'hA0 + 8'(n0), 1'b1, 8'hB0 + 8'(n1), 1'b0);
    checkVal("fair_full", full, 1);
    checkVal("fair_count", count, 16);

    for (int j = 0; j < 16; j++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      expWord = (j % 2 == 0) ? 8'hA0 + 8'(j / 2) : 8'hB0 + 8'(j / 2);
      checkVal("drain_valid", c_valid, 1);
      checkVal("drain_word", c_data, expWord);
    end
    checkVal("drain_empty", empty, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    checkVal("extra_rd_valid", c_valid, 0);

    doReset(2);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'($urandom), 1'b0, 8'h00, 1'b0);
    checkVal("sim_pre5", count, 5);
    applyStimulus(1'b1, 8'h77, 1'b0, 8'h00, 1'b1);
    checkVal("sim_at5", count, 5);
    for (int i = 0; i < 11; i++) applyStimulus(1'b0, 8'h00, 1'b1, 8'($urandom), 1'b0);
    checkVal("sim_pre16", count, 16);
    applyStimulus(1'b1, 8'h66, 1'b0, 8'h00, 1'b1);
    checkVal("sim_at16", count, 15);
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    checkVal("sim_pre0", count, 0);
    applyStimulus(1'b1, 8'h55, 1'b0, 8'h00, 1'b1);
    checkVal("sim_at0", count, 1);

    for (int i = 0; i < 400; i++) begin
      int wrBias;
      wrBias = ((i / 40) % 2 == 0) ? 3 : 1;
      applyStimulus(1'($urandom_range(0, 3) < wrBias), 8'($urandom),
                    1'($urandom_range(0, 3) < wrBias), 8'($urandom),
                    1'($urandom_range(0, 3) >= wrBias));
    end

    ovf = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    ovf = 1'b0;
    for (int i = 0; i < 4; i++)
      applyStimulus(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
    checkVal("err_sticky", err, 1);
    doReset(2);
    unf = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    unf = 1'b0;
    checkVal("err_underflow", err, 1);

    doReset(2);
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 8'($urandom), 1'b0, 8'h00, 1'b0);
    checkVal("mid_pre9", count, 9);
    p0_valid = 1'b1;
    p1_valid = 1'b1;
    c_rd_req = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput(-1, 1'b0, 8'h00);
    @(posedge clk);
    cycleNo++;
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b1, 8'h11, 1'b1, 8'h22, 1'b0);
    checkVal("mid_after_count", count, 1);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
